// File: rtl/accumulator_sequencer.sv
// Tile sequencer for the skewed accumulator: read side at step k, write/valid side at k+1.
// Optional ACC_SEQ_BOUNDS_CHECK_EN rejects tiles whose rows would run past DEPTH.
module accumulator_sequencer #(
    parameter int COLS  = 32,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [AW-1:0]   base_addr_i,
    input  logic [7:0]      rows_i,
    output logic            ready_o,
    output logic            done_o,
    output logic            err_o,
    output logic            vec_req_o,
    output logic            port1_rd_en_o,
    output logic            port2_wr_en_o,
    output logic            add_o,
    output logic [AW-1:0]   addr_rd_o,
    output logic [AW-1:0]   addr_wr_o,
    output logic [COLS-1:0] accum_addr_mask_o,
    output logic            out_valid_o,
    output logic [COLS-1:0] out_mask_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] OP_OVR = 2'd0;
    localparam logic [1:0] OP_ACC = 2'd1;
    localparam logic [1:0] OP_DRN = 2'd2;
    localparam int SW = ((AW > 8) ? AW : 8) + 1;

    logic [1:0]      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   base_q, base_d;
    logic [7:0]      n_q, n_d;
    logic [8:0]      k_q, k_d;
    logic            wr_en_q, wr_en_d;
    logic            add_q, add_d;
    logic [AW-1:0]   addr_wr_q, addr_wr_d;
    logic [COLS-1:0] wmask_q, wmask_d;
    logic            out_valid_q, out_valid_d;
    logic [COLS-1:0] out_mask_q, out_mask_d;

    logic            run;
    logic            start_ok;
    logic            oob;
    logic [AW-1:0]   cur_addr;
    logic [8:0]      last_k;
    logic [COLS-1:0] step_mask;

    assign run      = (state_q == S_RUN);
    assign cur_addr = base_q + k_q[AW-1:0];
    assign last_k   = {1'b0, n_q} + 9'(COLS - 2);

`ifdef ACC_SEQ_BOUNDS_CHECK_EN
    assign oob = (SW'(base_addr_i) + SW'(rows_i)) > SW'(DEPTH);
`else
    assign oob = 1'b0;
`endif

    assign start_ok = (op_i != 2'd3) && (rows_i != 8'd0) && (SW'(rows_i) <= SW'(DEPTH)) && !oob;

    // Column COLS-1-i of the skewed stream is live for k in [COLS-1-i, COLS-1-i+N-1].
    always_comb begin
        step_mask = '0;
        for (int i = 0; i < COLS; i++) begin
            step_mask[i] = ({1'b0, k_q} >= 10'(COLS - 1 - i)) &&
                           ({1'b0, k_q} <  (10'(COLS - 1 - i) + {2'b0, n_q}));
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        base_d      = base_q;
        n_d         = n_q;
        k_d         = k_q;
        wr_en_d     = run && (op_q != OP_DRN);
        add_d       = run && (op_q == OP_ACC);
        addr_wr_d   = (run && (op_q != OP_DRN)) ? cur_addr  : '0;
        wmask_d     = (run && (op_q != OP_DRN)) ? step_mask : '0;
        out_valid_d = run && (op_q == OP_DRN);
        out_mask_d  = (run && (op_q == OP_DRN)) ? step_mask : '0;
        case (state_q)
            S_IDLE: begin
                if (start_i && start_ok) begin
                    op_d    = op_i;
                    base_d  = base_addr_i;
                    n_d     = rows_i;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                k_d = k_q + 9'd1;
                if (k_q == last_k) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            op_q        <= OP_OVR;
            base_q      <= '0;
            n_q         <= '0;
            k_q         <= '0;
            wr_en_q     <= 1'b0;
            add_q       <= 1'b0;
            addr_wr_q   <= '0;
            wmask_q     <= '0;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            base_q      <= base_d;
            n_q         <= n_d;
            k_q         <= k_d;
            wr_en_q     <= wr_en_d;
            add_q       <= add_d;
            addr_wr_q   <= addr_wr_d;
            wmask_q     <= wmask_d;
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
        end
    end

    assign ready_o           = (state_q == S_IDLE);
    assign done_o            = (state_q == S_DONE);
    assign err_o             = ready_o && start_i && !start_ok;
    assign vec_req_o         = run && (op_q != OP_DRN);
    assign port1_rd_en_o     = run && (op_q != OP_OVR);
    assign addr_rd_o         = port1_rd_en_o ? cur_addr : '0;
    assign port2_wr_en_o     = wr_en_q;
    assign add_o             = add_q;
    assign addr_wr_o         = addr_wr_q;
    assign accum_addr_mask_o = wmask_q;
    assign out_valid_o       = out_valid_q;
    assign out_mask_o        = out_mask_q;
endmodule

// File: tb/tb_accumulator_sequencer.sv
// Bench for accumulator_sequencer: per-cycle trace checks against a timeline model of each tile.
module tb_accumulator_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_i, start_i;
    logic [1:0]  op_i;
    logic [6:0]  base_addr_i;
    logic [7:0]  rows_i;
    logic        ready_o, done_o, err_o, vec_req_o, port1_rd_en_o, port2_wr_en_o, add_o;
    logic [6:0]  addr_rd_o, addr_wr_o;
    logic [31:0] accum_addr_mask_o, out_mask_o;
    logic        out_valid_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    accumulator_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .base_addr_i(base_addr_i), .rows_i(rows_i), .ready_o(ready_o), .done_o(done_o),
        .err_o(err_o), .vec_req_o(vec_req_o), .port1_rd_en_o(port1_rd_en_o),
        .port2_wr_en_o(port2_wr_en_o), .add_o(add_o), .addr_rd_o(addr_rd_o),
        .addr_wr_o(addr_wr_o), .accum_addr_mask_o(accum_addr_mask_o),
        .out_valid_o(out_valid_o), .out_mask_o(out_mask_o)
    );

    typedef struct packed {
        logic        ready, done, err, vec_req, rd_en, wr_en, add, out_valid;
        logic [6:0]  addr_rd, addr_wr;
        logic [31:0] wmask, out_mask;
    } outs_t;

    typedef struct {
        int op; int b; int n; bit hold; int rst_t;
    } vec_t;

    // Columns c with 0 <= kw-c <= n-1 are live; column c maps to mask bit 31-c.
    function automatic logic [31:0] col_mask(int kw, int n);
        logic [31:0] m = '0;
        for (int c = 0; c < 32; c++)
            if (kw - c >= 0 && kw - c <= n - 1) m[31 - c] = 1'b1;
        return m;
    endfunction

    function automatic bit is_err(int op, int b, int n);
        bit e = (op == 3) || (n == 0) || (n > 128);
`ifdef ACC_SEQ_BOUNDS_CHECK_EN
        if (b + n > 128) e = 1'b1;
`endif
        return e;
    endfunction

    // t counts cycles from the accepting cycle (t=0); step k is live at t=k+1, its write at t=k+2.
    function automatic outs_t model(int op, int b, int n, int t);
        outs_t e = '0;
        int L  = n + 31;
        int k  = t - 1;
        int kw = t - 2;
        e.ready = (t == 0);
        if (k >= 0 && k < L) begin
            e.vec_req = (op != 2);
            e.rd_en   = (op != 0);
            if (op != 0) e.addr_rd = 7'((b + k) % 128);
        end
        if (kw >= 0 && kw < L) begin
            if (op == 2) begin
                e.out_valid = 1'b1;
                e.out_mask  = col_mask(kw, n);
            end else begin
                e.wr_en   = 1'b1;
                e.add     = (op == 1);
                e.addr_wr = 7'((b + kw) % 128);
                e.wmask   = col_mask(kw, n);
            end
        end
        e.done = (t == L + 1);
        return e;
    endfunction

    function automatic outs_t sample();
        outs_t a;
        a.ready = ready_o; a.done = done_o; a.err = err_o; a.vec_req = vec_req_o;
        a.rd_en = port1_rd_en_o; a.wr_en = port2_wr_en_o; a.add = add_o;
        a.out_valid = out_valid_o; a.addr_rd = addr_rd_o; a.addr_wr = addr_wr_o;
        a.wmask = accum_addr_mask_o; a.out_mask = out_mask_o;
        return a;
    endfunction

    task automatic check(string nm, outs_t a, outs_t e);
        if (!e.rd_en) a.addr_rd = '0;
        if (!e.wr_en) begin a.addr_wr = '0; a.wmask = '0; end
        if (!e.out_valid) a.out_mask = '0;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, a, e);
        end
    endtask

    task automatic check_int(string nm, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, a, e);
        end
    endtask

    // Entered just after a rising edge; leaves just after the rising edge following the last cycle.
    task automatic do_op(input vec_t v, input string nm);
        bit   err  = is_err(v.op, v.b, v.n);
        int   L    = v.n + 31;
        int   last = err ? 0 : L + 1;
        int   wr   = 0;
        int   vv   = 0;
        outs_t e;
        for (int t = 0; t <= last; t++) begin
            start_i = (t == 0) || v.hold;
            op_i = 2'(v.op); base_addr_i = 7'(v.b); rows_i = 8'(v.n);
            rst_i = (t == v.rst_t);
            @(negedge clk_i);
            e = model(v.op, v.b, v.n, t);
            e.err = (t == 0) && err;
            check($sformatf("%s t=%0d", nm, t), sample(), e);
            wr += int'(port2_wr_en_o);
            vv += int'(out_valid_o);
            @(posedge clk_i); #1;
            if (t == v.rst_t) break;
        end
        rst_i = 1'b0;
        if (!v.hold) start_i = 1'b0;
        if (!err && v.rst_t < 0) begin
            check_int({nm, " writes"}, wr, (v.op == 2) ? 0 : L);
            check_int({nm, " valids"}, vv, (v.op == 2) ? L : 0);
        end
    endtask

    vec_t tbl[$];

    initial begin
        outs_t idle_e;
        idle_e = '0;
        idle_e.ready = 1'b1;
        rst_i = 1'b1; start_i = 1'b0; op_i = '0; base_addr_i = '0; rows_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset", sample(), idle_e);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        tbl.push_back('{1, 0,   8,  1'b0, 6});
        tbl.push_back('{0, 10,  4,  1'b0, -1});
        tbl.push_back('{1, 0,   1,  1'b0, -1});
        tbl.push_back('{2, 120, 16, 1'b0, -1});
        tbl.push_back('{3, 5,   4,  1'b0, -1});
        tbl.push_back('{0, 5,   0,  1'b0, -1});
        tbl.push_back('{1, 100, 64, 1'b0, -1});
        tbl.push_back('{0, 3,   2,  1'b1, -1});
        tbl.push_back('{1, 7,   3,  1'b0, -1});
        tbl.push_back('{2, 0,   128, 1'b0, -1});
        foreach (tbl[i]) do_op(tbl[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 24; r++) begin
            vec_t v;
            v.op    = int'($urandom_range(0, 3));
            v.b     = int'($urandom_range(0, 127));
            v.n     = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 128));
            v.hold  = 1'b0;
            v.rst_t = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 20)) : -1;
            do_op(v, $sformatf("rnd%0d", r));
        end

        @(negedge clk_i);
        check("final idle", sample(), idle_e);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
